// File: rtl/lane_merge_pkg.sv
// lane_merge_pkg -- shared sizes and types for the nine-lane merge FIFO.
// Rev 1.0
`default_nettype none

package lane_merge_pkg;

    localparam int NLANES = 9;
    localparam int DW     = 9;
    localparam int DEPTH  = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(NLANES + 1);

    typedef logic [DW-1:0]    lane_data_t;
    typedef logic [CNT_W-1:0] lane_cnt_t;

endpackage

`default_nettype wire

// File: rtl/lane_merge_fifo_prefix.sv
// lane_prefix_cnt -- exclusive prefix popcount of the lane enables plus total.
// Rev 1.0
`default_nettype none

module lane_prefix_cnt
    import lane_merge_pkg::*;
(
    input  logic [NLANES-1:0]            wen,
    output logic [NLANES-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]             total
);

    lane_cnt_t acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int k = 0; k < NLANES; k++) begin
            offset[k] = acc;
            acc       = acc + CNT_W'(wen[k]);
        end
        total = acc;
    end

endmodule

`default_nettype wire

// File: rtl/lane_merge_fifo.sv
// lane_merge_fifo -- compacts up to nine write lanes per cycle into one show-ahead FIFO.
// Rev 1.0
`default_nettype none

module lane_merge_fifo
    import lane_merge_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NLANES-1:0] wen,
    input  logic [DW-1:0]     i_data0,
    input  logic [DW-1:0]     i_data1,
    input  logic [DW-1:0]     i_data2,
    input  logic [DW-1:0]     i_data3,
    input  logic [DW-1:0]     i_data4,
    input  logic [DW-1:0]     i_data5,
    input  logic [DW-1:0]     i_data6,
    input  logic [DW-1:0]     i_data7,
    input  logic [DW-1:0]     i_data8,
    input  logic              ren,
    output logic              valid,
    output logic [DW-1:0]     o_data,
    output logic              freeze_clk,
    output logic              overflow,
    output logic [LVL_W-1:0]  level
);

    lane_data_t                  lane_data [NLANES];
    lane_data_t                  mem [DEPTH];
    logic [NLANES-1:0][CNT_W-1:0] offset;
    logic [CNT_W-1:0]            total;
    logic [CNT_W-1:0]            accepted;
    logic [LVL_W-1:0]            free;
    logic [NLANES-1:0]           lane_ok;
    logic                        dropped;
    logic                        pop;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;

    assign lane_data[0] = i_data0;
    assign lane_data[1] = i_data1;
    assign lane_data[2] = i_data2;
    assign lane_data[3] = i_data3;
    assign lane_data[4] = i_data4;
    assign lane_data[5] = i_data5;
    assign lane_data[6] = i_data6;
    assign lane_data[7] = i_data7;
    assign lane_data[8] = i_data8;

    lane_prefix_cnt u_prefix (
        .wen    (wen),
        .offset (offset),
        .total  (total)
    );

    // Space is judged on the registered level, so a same-cycle pop never makes room.
    assign free       = LVL_W'(DEPTH) - level;
    assign dropped    = LVL_W'(total) > free;
    assign accepted   = dropped ? free[CNT_W-1:0] : total;
    assign pop        = ren && valid;
    assign valid      = (level != '0);
    assign freeze_clk = free < LVL_W'(NLANES);

    for (genvar k = 0; k < NLANES; k++) begin : g_lane_ok
        assign lane_ok[k] = wen[k] && (LVL_W'(offset[k]) < free);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NLANES; k++) begin
            if (lane_ok[k]) begin
                mem[wr_ptr + PTR_W'(offset[k])] <= lane_data[k];
            end
        end
    end

    // Gating on valid keeps the unreset memory off the output after reset.
    assign o_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(accepted);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(accepted) - LVL_W'(pop);
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lane_merge_fifo.sv
// tb_lane_merge_fifo -- directed self-checking bench for lane_merge_fifo.
// Rev 1.0
`default_nettype none

module tb_lane_merge_fifo;

    logic       clk;
    logic       reset_n;
    logic [8:0] wen;
    logic [8:0] din [9];
    logic       ren;
    logic       valid;
    logic [8:0] o_data;
    logic       freeze_clk;
    logic       overflow;
    logic [5:0] level;

    int n_vec = 0;
    int n_err = 0;

    lane_merge_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wen        (wen),
        .i_data0    (din[0]),
        .i_data1    (din[1]),
        .i_data2    (din[2]),
        .i_data3    (din[3]),
        .i_data4    (din[4]),
        .i_data5    (din[5]),
        .i_data6    (din[6]),
        .i_data7    (din[7]),
        .i_data8    (din[8]),
        .ren        (ren),
        .valid      (valid),
        .o_data     (o_data),
        .freeze_clk (freeze_clk),
        .overflow   (overflow),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < 9; k++) din[k] = '0;
    endtask

    initial begin
        lane_data_t_dummy_init();
    end

    task automatic lane_data_t_dummy_init();
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] pend[$];
        logic [8:0] m;
        int sent, pat, cyc, w;

        reset_n = 1'b0;
        wen     = '0;
        ren     = 1'b0;
        clear_lanes();
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_odata", o_data, 0);
        check("rst_freeze", freeze_clk, 0);
        reset_n = 1'b1;
        tick();

        // All nine lanes, then nine pops.
        wen = 9'h1FF;
        for (int k = 0; k < 9; k++) din[k] = 9'(k + 1);
        check("pre_write_valid", valid, 0);
        tick();
        wen = '0;
        clear_lanes();
        check("full9_valid", valid, 1);
        check("full9_level", level, 9);
        for (int i = 0; i < 9; i++) begin
            check("full9_odata", o_data, i + 1);
            ren = 1'b1;
            tick();
        end
        ren = 1'b0;
        check("full9_empty_valid", valid, 0);
        check("full9_empty_level", level, 0);

        // Sparse lanes compact in ascending index.
        wen = 9'b100010001;
        din[0] = 9'h0A;
        din[4] = 9'h0B;
        din[8] = 9'h0C;
        tick();
        wen = '0;
        clear_lanes();
        check("sparse_level", level, 3);
        check("sparse_odata0", o_data, 9'h0A);
        ren = 1'b1;
        tick();
        check("sparse_odata1", o_data, 9'h0B);
        tick();
        check("sparse_odata2", o_data, 9'h0C);
        tick();
        ren = 1'b0;
        check("sparse_empty", valid, 0);

        // Fill to 27, then overfill.
        for (int c = 0; c < 3; c++) begin
            wen = 9'h1FF;
            for (int k = 0; k < 9; k++) din[k] = 9'(c * 9 + k);
            tick();
        end
        wen = '0;
        clear_lanes();
        check("fill27_level", level, 27);
        check("fill27_freeze", freeze_clk, 1);
        check("fill27_overflow", overflow, 0);
        wen = 9'h1FF;
        for (int k = 0; k < 9; k++) din[k] = 9'(27 + k);
        tick();
        wen = '0;
        clear_lanes();
        check("fill32_level", level, 32);
        check("fill32_overflow", overflow, 1);
        check("fill32_freeze", freeze_clk, 1);
        check("fill32_odata", o_data, 0);

        // Full with pop plus nine writes: pop only.
        ren = 1'b1;
        wen = 9'h1FF;
        for (int k = 0; k < 9; k++) din[k] = 9'(9'h100 + k);
        tick();
        ren = 1'b0;
        wen = '0;
        clear_lanes();
        check("fullpop_level", level, 31);
        check("fullpop_odata", o_data, 1);
        for (int i = 1; i < 32; i++) begin
            check("drain_odata", o_data, i);
            ren = 1'b1;
            tick();
        end
        ren = 1'b0;
        check("drain_valid", valid, 0);
        check("drain_overflow_sticky", overflow, 1);

        // Async reset at level 14.
        wen = 9'h1FF;
        for (int k = 0; k < 9; k++) din[k] = 9'(9'h50 + k);
        tick();
        wen = 9'h01F;
        for (int k = 0; k < 9; k++) din[k] = 9'(9'h60 + k);
        tick();
        wen = '0;
        clear_lanes();
        check("pre_areset_level", level, 14);
        check("pre_areset_overflow", overflow, 1);
        #1 reset_n = 1'b0;
        #1;
        check("areset_valid", valid, 0);
        check("areset_level", level, 0);
        check("areset_overflow", overflow, 0);
        check("areset_odata", o_data, 0);
        #1 reset_n = 1'b1;
        tick();
        wen = 9'h008;
        din[3] = 9'h1A5;
        tick();
        wen = '0;
        clear_lanes();
        check("post_reset_valid", valid, 1);
        check("post_reset_odata", o_data, 9'h1A5);
        check("post_reset_level", level, 1);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("post_reset_empty", level, 0);

        // Streaming across pointer wrap, source honours backpressure.
        sent = 0;
        pat  = 0;
        cyc  = 0;
        while ((sent < 100 || q.size() != 0) && cyc < 2000) begin
            check("wrap_valid", valid, q.size() != 0);
            if (q.size() != 0) check("wrap_odata", o_data, q[0]);
            check("wrap_freeze", freeze_clk, (32 - q.size()) < 9);
            check("wrap_level", level, q.size());
            ren = 1'b1;
            clear_lanes();
            m = '0;
            if (((32 - q.size()) >= 9) && sent < 100) begin
                case (pat % 3)
                    0:       m = 9'h100;
                    1:       m = 9'h0A4;
                    default: m = 9'h1FF;
                endcase
                w = $countones(m);
                if (100 - sent < w) m = 9'((1 << (100 - sent)) - 1);
                pat++;
            end
            wen = m;
            for (int k = 0; k < 9; k++) begin
                if (m[k]) begin
                    din[k] = 9'(sent);
                    pend.push_back(9'(sent));
                    sent++;
                end
            end
            tick();
            cyc++;
            if (q.size() != 0) q.delete(0);
            while (pend.size() != 0) begin
                q.push_back(pend[0]);
                pend.delete(0);
            end
        end
        ren = 1'b0;
        wen = '0;
        clear_lanes();
        check("wrap_done", (sent == 100) && (q.size() == 0), 1);
        check("wrap_overflow", overflow, 0);
        check("wrap_end_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lane_merge_fifo.md
Name: lane_merge_fifo

Overview:
- Merges up to nine 9-bit write lanes per cycle into one in-order FIFO.
- Drained one word per cycle through a show-ahead read port (valid/o_data/ren).
- Sits directly downstream of the lane source and feeds the single-stream consumer.
- freeze_clk is the backpressure signal to the lane source.

Parameters:
- NLANES, 9, number of write lanes; fixed at 9 to match port list.
- DW, 9, data width per lane.
- DEPTH, 32, FIFO entries; power of 2, must be >= 2*NLANES.

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- wen  in  9  per-lane write enable; bit k qualifies i_datak
- i_data0  in  9  lane 0 data
- i_data1  in  9  lane 1 data
- i_data2  in  9  lane 2 data
- i_data3  in  9  lane 3 data
- i_data4  in  9  lane 4 data
- i_data5  in  9  lane 5 data
- i_data6  in  9  lane 6 data
- i_data7  in  9  lane 7 data
- i_data8  in  9  lane 8 data
- ren  in  1  pop request; ignored when valid=0
- valid  out  1  FIFO non-empty
- o_data  out  9  head-of-FIFO word (show-ahead)
- freeze_clk  out  1  backpressure: free space < NLANES
- overflow  out  1  sticky; set when any enabled lane is dropped
- level  out  6  current occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, level=0, valid=0, overflow=0, o_data=0. freeze_clk=0 because free=DEPTH. Memory contents are not reset.
- Write ordering: enabled lanes are compacted in ascending lane index. Lane k writes to wr_ptr + popcount(wen[k-1:0]), modulo DEPTH.
- Free space: free = DEPTH - level, computed from the registered level before this cycle's pop. A same-cycle pop does not free space for same-cycle writes.
- Accepted count: accepted = min(popcount(wen), free). Lanes whose compacted offset is >= free are dropped.
- Overflow: set on the edge after any drop. Cleared only by reset.
- Pointer update: wr_ptr += accepted. On ren && valid: rd_ptr += 1. Pointers wrap modulo DEPTH.
- Level update: level_next = level + accepted - (ren && valid). Both happen in the same cycle.
- Read port: valid = (level != 0). o_data = mem[rd_ptr], combinational from the registered pointer. A write to an empty FIFO becomes visible on the next cycle (1-cycle latency).
- Backpressure: freeze_clk = (free < NLANES), combinational from registered level. The source must hold off writes while it is high. Writes issued anyway are handled by the drop rule.
- Edge cases:
  - ren while empty: no effect.
  - wen=0: no effect.
  - Full FIFO with simultaneous pop and 9 writes: pop only, all 9 dropped, overflow set.
  - Reset mid-burst empties the FIFO; in-flight data is discarded.

Decomposition:
- Package lane_merge_pkg holds: NLANES, DW, DEPTH, PTR_W=$clog2(DEPTH), LVL_W=$clog2(DEPTH+1), typedef lane_data_t (logic [DW-1:0]).
- Sub-module lane_prefix_cnt is combinational. It takes wen[8:0] and outputs a per-lane offset (exclusive prefix popcount, 4 bits each) plus the total (4 bits).
- Top level holds the memory, pointers, level, overflow and the drop compare.

Test Plan:
- Reset, then wen=9'h1FF, i_dataK=K+1 for one cycle, then ren=1 for 9 cycles -> valid one cycle after the write; o_data reads 1,2,...,9; then valid=0, level=0.
- Sparse lanes: wen=9'b100010001, i_data0=0x0A, i_data4=0x0B, i_data8=0x0C -> level=3; pops return 0x0A, 0x0B, 0x0C in order.
- Fill: 3 cycles of wen=9'h1FF -> level=27, freeze_clk=1 (free 5 < 9). Next wen=9'h1FF -> lanes 0..4 accepted, lanes 5..8 dropped; level=32, overflow=1.
- Full with simultaneous ren=1 and wen=9'h1FF -> level=31; all 9 dropped; o_data advances by one.
- Wrap-around: stream 100 words at mixed widths (1, 3, 9 per cycle) with ren=1 continuously -> output order identical to input order across pointer wrap; overflow stays 0 while the source honours freeze_clk.
- Async reset asserted mid-stream at level=14 -> valid, level and overflow go to 0 immediately, without waiting for a clk edge; the first post-reset write is read back correctly.
